// File: rtl/fetch_pkg.sv
// fetch_pkg: FSM states and constants shared by the fetch stage
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP = 32'd4;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction memory port, decode handshake and redirect of the fetch stage
interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid,
    input  imem_valid, imem_rdata, instr_ready, redirect, redirect_pc
  );
  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid,
    output imem_valid, imem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular buffer of {pc, instr} entries; flush wins over push
module fetch_fifo #(
  parameter  int DEPTH = 2,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [63:0]   data_i,
  output logic [63:0]   data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    rd_d  = pop_i ? (rd_q == AW'(DEPTH - 1) ? '0 : rd_q + 1'b1) : rd_q;
    wr_d  = push_i ? (wr_q == AW'(DEPTH - 1) ? '0 : wr_q + 1'b1) : wr_q;
    cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (push_i && !flush_i) mem_q[wr_q] <= data_i;
  assign data_o  = mem_q[rd_q];
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, single-outstanding imem FSM and instruction buffer feeding decode
// Define FETCH_PERF_EN to add the perf_fetched/perf_stall counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  fetch_if.master     bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          req, push, pop, full, empty;
  logic [CW-1:0] count;
  logic [63:0]   head;
  assign pop = !empty && bus.instr_ready;
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop && !bus.redirect),
    .flush_i (bus.redirect),
    .data_i  ({pc_q, bus.imem_rdata}),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    push          = 1'b0;
    req           = 1'b0;
    bus.imem_addr = pc_q;
    if (bus.redirect) begin
      pc_d    = bus.redirect_pc & ~32'd3;
      state_d = (state_q != IDLE && !bus.imem_valid) ? DROP : IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          req     = !full || pop;
          state_d = req ? WAIT : IDLE;
        end
        WAIT: if (bus.imem_valid) begin
          push          = 1'b1;
          pc_d          = pc_q + PC_STEP;
          // issue the next request only if its response already has a slot
          req           = 32'(count) + 32'd1 - 32'(pop) < 32'(FIFO_DEPTH);
          bus.imem_addr = pc_d;
          state_d       = req ? WAIT : IDLE;
        end
        DROP: state_d = bus.imem_valid ? IDLE : DROP;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  assign bus.imem_req    = req && !rst;
  assign bus.instr_valid = !empty;
  assign bus.instr       = empty ? NOP_INSTR : head[31:0];
  assign bus.instr_pc    = empty ? '0 : head[63:32];
`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, stall_q;
  always_ff @(posedge clk)
    if (rst) begin
      fetched_q <= '0;
      stall_q   <= '0;
    end else begin
      fetched_q <= fetched_q + 32'(pop);
      stall_q   <= stall_q + 32'(empty && bus.instr_ready);
    end
  assign perf_fetched = fetched_q;
  assign perf_stall   = stall_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit with a latency-configurable memory responder
module tb_fetch_unit;
  import fetch_pkg::*;
  logic clk, rst;
  fetch_if f();
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall;
`endif
  fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (f)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
`endif
  );
  int checks = 0, failures = 0;
  int lat = 1, pend_cnt = 0;
  bit pend = 0;
  logic [31:0] pend_addr;
  logic s_req, s_iv;
  logic [31:0] s_addr, s_pc, s_in;
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  function automatic logic [31:0] md(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction
  // one clock: drive memory response, sample outputs, record any request, advance past the edge
  task automatic cycle();
    if (pend && pend_cnt == 1) begin
      f.imem_valid = 1'b1;
      f.imem_rdata = md(pend_addr);
      pend = 0;
    end else begin
      f.imem_valid = 1'b0;
      f.imem_rdata = 32'hBAD0_BAD0;
      if (pend) pend_cnt--;
    end
    #1;
    s_req = f.imem_req; s_addr = f.imem_addr;
    s_iv = f.instr_valid; s_pc = f.instr_pc; s_in = f.instr;
    if (s_req === 1'b1 && !rst) begin
      checks++;
      if (pend) begin
        $display("FAIL one_outstanding: req at addr=%h while addr=%h still pending", s_addr, pend_addr);
        failures++;
      end
      pend = 1; pend_cnt = lat; pend_addr = s_addr;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1; f.instr_ready = 0; f.redirect = 0; f.redirect_pc = 0; pend = 0;
    cycle(); cycle();
    rst = 0; pend = 0;
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if ({s_req, s_iv, s_in, s_pc} !== {1'b0, 1'b0, NOP_INSTR, 32'h0}) begin
      $display("FAIL reset_state: req=%b iv=%b instr=%h pc=%h, need 0 0 %h 0", s_req, s_iv, s_in, s_pc, NOP_INSTR);
      failures++;
    end
`ifdef FETCH_PERF_EN
    checks++;
    if ({perf_fetched, perf_stall} !== 64'h0) begin
      $display("FAIL reset_perf: fetched=%0d stall=%0d, need 0 0", perf_fetched, perf_stall);
      failures++;
    end
`endif
  endtask
  task automatic test_stream();
    logic [31:0] ea, ep, ei;
    logic ev;
    do_reset(); lat = 1; f.instr_ready = 1;
    for (int i = 1; i <= 6; i++) begin
      cycle();
      ea = 32'(4 * (i - 1));
      checks++;
      if ({s_req, s_addr} !== {1'b1, ea}) begin
        $display("FAIL stream_req c%0d: req=%b addr=%h, need 1 %h", i, s_req, s_addr, ea);
        failures++;
      end
      ev = i >= 3; ep = i >= 3 ? 32'(4 * (i - 3)) : 32'h0; ei = i >= 3 ? md(ep) : NOP_INSTR;
      checks++;
      if ({s_iv, s_pc, s_in} !== {ev, ep, ei}) begin
        $display("FAIL stream_out c%0d: iv=%b pc=%h instr=%h, need %b %h %h", i, s_iv, s_pc, s_in, ev, ep, ei);
        failures++;
      end
    end
  endtask
  task automatic test_backpressure();
    logic [32:0] er [1:5];
    do_reset(); lat = 1;
    er[1] = {1'b1, 32'h0}; er[2] = {1'b1, 32'h4}; er[3] = 33'h0; er[4] = 33'h0; er[5] = 33'h0;
    for (int i = 1; i <= 5; i++) begin
      cycle();
      checks++;
      if (s_req !== er[i][32] || (s_req && s_addr !== er[i][31:0])) begin
        $display("FAIL bp_req c%0d: req=%b addr=%h, need %b %h", i, s_req, s_addr, er[i][32], er[i][31:0]);
        failures++;
      end
    end
    f.instr_ready = 1;
    cycle();
    checks++;
    if ({s_iv, s_pc, s_req, s_addr} !== {1'b1, 32'h0, 1'b1, 32'h8}) begin
      $display("FAIL bp_resume: iv=%b pc=%h req=%b addr=%h, need 1 0 1 8", s_iv, s_pc, s_req, s_addr);
      failures++;
    end
    cycle();
    checks++;
    if ({s_iv, s_pc, s_req, s_addr} !== {1'b1, 32'h4, 1'b1, 32'hC}) begin
      $display("FAIL bp_second: iv=%b pc=%h req=%b addr=%h, need 1 4 1 c", s_iv, s_pc, s_req, s_addr);
      failures++;
    end
    cycle();
    checks++;
    if ({s_iv, s_pc, s_in} !== {1'b1, 32'h8, md(32'h8)}) begin
      $display("FAIL bp_third: iv=%b pc=%h instr=%h, need 1 8 %h", s_iv, s_pc, s_in, md(32'h8));
      failures++;
    end
  endtask
  task automatic test_redirect_drop();
    do_reset(); lat = 3; f.instr_ready = 1;
    cycle();
    f.redirect = 1; f.redirect_pc = 32'h103;
    cycle();
    f.redirect = 0;
    checks++;
    if (s_req !== 1'b0) begin
      $display("FAIL drop_redirect_req: req=%b, need 0", s_req);
      failures++;
    end
    for (int i = 3; i <= 4; i++) begin
      cycle();
      checks++;
      if ({s_req, s_iv} !== 2'b00) begin
        $display("FAIL drop_wait c%0d: req=%b iv=%b, need 0 0", i, s_req, s_iv);
        failures++;
      end
    end
    lat = 1;
    cycle();
    checks++;
    if ({s_req, s_addr, s_iv} !== {1'b1, 32'h100, 1'b0}) begin
      $display("FAIL drop_refetch: req=%b addr=%h iv=%b, need 1 100 0", s_req, s_addr, s_iv);
      failures++;
    end
    cycle();
    cycle();
    checks++;
    if ({s_iv, s_pc, s_in} !== {1'b1, 32'h100, md(32'h100)}) begin
      $display("FAIL drop_first_out: iv=%b pc=%h instr=%h, need 1 100 %h", s_iv, s_pc, s_in, md(32'h100));
      failures++;
    end
  endtask
  task automatic test_redirect_pop();
    do_reset(); lat = 1; f.instr_ready = 1;
    cycle(); cycle();
    f.redirect = 1; f.redirect_pc = 32'h200;
    cycle();
    f.redirect = 0;
    checks++;
    if ({s_req, s_iv} !== 2'b01) begin
      $display("FAIL rp_same_cycle: req=%b iv=%b, need 0 1", s_req, s_iv);
      failures++;
    end
    cycle();
    checks++;
    if ({s_iv, s_req, s_addr} !== {1'b0, 1'b1, 32'h200}) begin
      $display("FAIL rp_after: iv=%b req=%b addr=%h, need 0 1 200", s_iv, s_req, s_addr);
      failures++;
    end
    cycle(); cycle();
    checks++;
    if ({s_iv, s_pc} !== {1'b1, 32'h200}) begin
      $display("FAIL rp_first_out: iv=%b pc=%h, need 1 200", s_iv, s_pc);
      failures++;
    end
  endtask
  task automatic test_wrap();
    do_reset(); lat = 1; f.instr_ready = 1;
    f.redirect = 1; f.redirect_pc = 32'hFFFF_FFFF;
    cycle();
    f.redirect = 0;
    checks++;
    if (s_req !== 1'b0) begin
      $display("FAIL wrap_redirect_req: req=%b, need 0", s_req);
      failures++;
    end
    cycle();
    checks++;
    if ({s_req, s_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      $display("FAIL wrap_first: req=%b addr=%h, need 1 fffffffc", s_req, s_addr);
      failures++;
    end
    cycle();
    checks++;
    if ({s_req, s_addr} !== {1'b1, 32'h0}) begin
      $display("FAIL wrap_next: req=%b addr=%h, need 1 00000000", s_req, s_addr);
      failures++;
    end
    cycle();
    checks++;
    if ({s_iv, s_pc, s_in} !== {1'b1, 32'hFFFF_FFFC, 32'h2152_FFFC}) begin
      $display("FAIL wrap_out: iv=%b pc=%h instr=%h, need 1 fffffffc 2152fffc", s_iv, s_pc, s_in);
      failures++;
    end
  endtask
`ifdef FETCH_PERF_EN
  task automatic test_perf();
    do_reset(); lat = 1; f.instr_ready = 1;
    for (int i = 1; i <= 7; i++) cycle();
    f.instr_ready = 0; f.redirect = 1; f.redirect_pc = 32'h40;
    cycle();
    f.redirect = 0;
    cycle();
    f.instr_ready = 1;
    cycle();
    checks++;
    if ({perf_fetched, perf_stall} !== {32'd5, 32'd3}) begin
      $display("FAIL perf_counts: fetched=%0d stall=%0d, need 5 3", perf_fetched, perf_stall);
      failures++;
    end
    rst = 1; pend = 0;
    cycle();
    rst = 0;
    checks++;
    if ({perf_fetched, perf_stall} !== 64'h0) begin
      $display("FAIL perf_clear: fetched=%0d stall=%0d, need 0 0", perf_fetched, perf_stall);
      failures++;
    end
  endtask
`endif
  initial begin
    rst = 1; f.imem_valid = 0; f.imem_rdata = 0; f.instr_ready = 0; f.redirect = 0; f.redirect_pc = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_redirect_pop();
    test_wrap();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
